// File: rtl/sram_confreg_responder.sv
// sram_confreg_responder: configuration-register window on the data SRAM bus.
// Holds the CTRL/COUNT/COMPARE/STATUS timer, the LED, SWITCH and SCRATCH registers,
// and drives the timer interrupt back into the CPU.
// Build option: define CONFREG_TIMER_EN to include the timer registers and interrupt.
// Without it, offsets 0x0000-0x000C read 0, writes to them are dropped,
// and timer_int is tied low.
module sram_confreg_responder #(
    parameter logic [15:0] BASE_HI    = 16'hBFAF,
    parameter logic [31:0] COUNT_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic        timer_int
);

    // Word index within the window; byte offset bits [1:0] are ignored.
    localparam logic [13:0] IDX_CTRL    = 14'd0;
    localparam logic [13:0] IDX_COUNT   = 14'd1;
    localparam logic [13:0] IDX_COMPARE = 14'd2;
    localparam logic [13:0] IDX_STATUS  = 14'd3;
    localparam logic [13:0] IDX_LED     = 14'd4;
    localparam logic [13:0] IDX_SWITCH  = 14'd5;
    localparam logic [13:0] IDX_SCRATCH = 14'd6;

    logic        hit;
    logic        rd_req;
    logic        wr_req;
    logic [13:0] idx;
    logic [31:0] rd_val;
    logic [7:0]  switch_meta;
    logic [7:0]  switch_sync;
    logic [15:0] led_q;
    logic [31:0] scratch_q;
    logic        unused_bits;

    assign hit    = sram_en && (sram_addr[31:16] == BASE_HI);
    assign idx    = sram_addr[15:2];
    assign rd_req = sram_en && (sram_wen == 4'b0000);
    assign wr_req = hit && (sram_wen != 4'b0000);

    assign unused_bits = ^{sram_addr[1:0], COUNT_INIT};

    // Byte-lane merge: lanes with their enable set take the new data.
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            switch_meta <= '0;
            switch_sync <= '0;
        end else begin
            switch_meta <= switch_in;
            switch_sync <= switch_meta;
        end
    end

    // LED and SCRATCH registers with per-lane write enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            scratch_q <= '0;
        end else if (wr_req) begin
            if (idx == IDX_LED) begin
                if (sram_wen[0]) led_q[7:0]  <= sram_wdata[7:0];
                if (sram_wen[1]) led_q[15:8] <= sram_wdata[15:8];
            end
            if (idx == IDX_SCRATCH)
                scratch_q <= merge(scratch_q, sram_wdata, sram_wen);
        end
    end

    assign led_out = led_q;

`ifdef CONFREG_TIMER_EN
    logic [1:0]  ctrl_q;       // [0] timer_en, [1] int_en
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        pending_q;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_compare;
    logic        w1c_status;
    logic        match;

    assign wr_ctrl    = wr_req && (idx == IDX_CTRL) && sram_wen[0];
    assign wr_count   = wr_req && (idx == IDX_COUNT);
    assign wr_compare = wr_req && (idx == IDX_COMPARE);
    assign w1c_status = wr_req && (idx == IDX_STATUS) && sram_wen[0] && sram_wdata[0];
    // A COMPARE write in the same cycle hides the match against the old value.
    assign match      = ctrl_q[0] && (count_q == compare_q) && !wr_compare;

    // Timer state: software writes beat the increment; a COMPARE write clears
    // pending; a match beats a simultaneous W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            count_q   <= COUNT_INIT;
            compare_q <= 32'hFFFF_FFFF;
            pending_q <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl_q <= sram_wdata[1:0];
            if (wr_count)
                count_q <= merge(count_q, sram_wdata, sram_wen);
            else if (ctrl_q[0])
                count_q <= count_q + 32'd1;
            if (wr_compare)
                compare_q <= merge(compare_q, sram_wdata, sram_wen);
            if (wr_compare)
                pending_q <= 1'b0;
            else if (match)
                pending_q <= 1'b1;
            else if (w1c_status)
                pending_q <= 1'b0;
        end
    end

    assign timer_int = pending_q && ctrl_q[1];
`else
    assign timer_int = 1'b0;
`endif

    // Read mux over current register values (pre-update view of this edge).
    always_comb begin
        rd_val = '0;
        case (idx)
`ifdef CONFREG_TIMER_EN
            IDX_CTRL:    rd_val = {30'b0, ctrl_q};
            IDX_COUNT:   rd_val = count_q;
            IDX_COMPARE: rd_val = compare_q;
            IDX_STATUS:  rd_val = {31'b0, pending_q};
`endif
            IDX_LED:     rd_val = {16'b0, led_q};
            IDX_SWITCH:  rd_val = {24'b0, switch_sync};
            IDX_SCRATCH: rd_val = scratch_q;
            default:     rd_val = '0;
        endcase
    end

    // Registered read data; holds across idle and write cycles, misses read 0.
    always_ff @(posedge clk) begin
        if (rst)
            sram_rdata <= '0;
        else if (rd_req)
            sram_rdata <= hit ? rd_val : 32'h0;
    end

endmodule

// File: tb/tb_sram_confreg_responder.sv
// Scoreboard bench for sram_confreg_responder: reads push their expected value,
// a monitor pops and compares one cycle later. Timer checks are selected by
// CONFREG_TIMER_EN to match the build.
module tb_sram_confreg_responder;

    localparam logic [31:0] BASE = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'b0;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_wdata = '0;
    logic [31:0] sram_rdata;
    logic [7:0]  switch_in = '0;
    logic [15:0] led_out;
    logic        timer_int;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    sram_confreg_responder dut (
        .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .switch_in(switch_in), .led_out(led_out), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string nm, input logic [15:0] off, input logic [31:0] exp);
        sram_en = 1'b1; sram_wen = 4'b0; sram_addr = BASE | {16'b0, off};
        exp_q.push_back(exp); name_q.push_back(nm);
        cyc();
        sram_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] be);
        sram_en = 1'b1; sram_wen = be; sram_addr = BASE | {16'b0, off}; sram_wdata = d;
        cyc();
        sram_en = 1'b0; sram_wen = 4'b0;
    endtask

    task automatic chk_now(input string nm, input logic [31:0] act, input logic [31:0] exp);
        @(negedge clk);
        check(nm, act, exp);
    endtask

    // Monitor: a read accepted at an edge is compared at the following negedge.
    initial begin
        logic take;
        forever begin
            @(posedge clk);
            take = sram_en && (sram_wen == 4'b0) && !rst;
            @(negedge clk);
            if (take) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow: got %08h expected none", sram_rdata);
                end else begin
                    check(name_q.pop_front(), sram_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        cyc(); cyc();
        rst = 1'b0;
        chk_now("reset_rdata", sram_rdata, 32'h0);
        chk_now("reset_led", {16'b0, led_out}, 32'h0);
        chk_now("reset_int", {31'b0, timer_int}, 32'h0);
        @(posedge clk); #1;

        rd("rst_led", 16'h0010, 32'h0);
        rd("rst_scratch", 16'h0018, 32'h0);
`ifdef CONFREG_TIMER_EN
        rd("rst_compare", 16'h0008, 32'hFFFF_FFFF);
`else
        rd("rst_compare_off", 16'h0008, 32'h0);
`endif

        // Byte-lane writes, then write-then-read next cycle
        wr(16'h0018, 32'hA5A5_A5A5, 4'b1111);
        wr(16'h0018, 32'h1234_5678, 4'b0101);
        rd("scratch_lanes", 16'h0018, 32'hA534_A578);
        // rdata holds over idle and write cycles
        cyc();
        wr(16'h0010, 32'h1234_ABCD, 4'b1111);
        chk_now("hold_rdata", sram_rdata, 32'hA534_A578);
        chk_now("led_out", {16'b0, led_out}, 32'h0000_ABCD);
        @(posedge clk); #1;
        rd("led_read", 16'h0010, 32'h0000_ABCD);
        rd("unmapped", 16'h0020, 32'h0);

        // Switch synchronizer, read-only, and miss
        switch_in = 8'h3C;
        cyc(); cyc();
        rd("switch", 16'h0014, 32'h0000_003C);
        wr(16'h0014, 32'hFFFF_FFFF, 4'b1111);
        rd("switch_ro", 16'h0014, 32'h0000_003C);
        sram_en = 1'b1; sram_wen = 4'b0; sram_addr = 32'h1234_0018;
        exp_q.push_back(32'h0); name_q.push_back("miss_read");
        cyc();
        sram_en = 1'b0;

`ifdef CONFREG_TIMER_EN
        // Interrupt on COUNT==COMPARE; COUNT is 0 after CTRL edge, 10 after ten more
        wr(16'h0008, 32'd10, 4'b1111);
        wr(16'h0004, 32'd0, 4'b1111);
        wr(16'h0000, 32'd3, 4'b0001);
        repeat (10) cyc();
        chk_now("int_before_match", {31'b0, timer_int}, 32'h0);
        @(posedge clk); #1;
        chk_now("int_after_match", {31'b0, timer_int}, 32'h1);
        @(posedge clk); #1;
        rd("status_pending", 16'h000C, 32'h1);
        wr(16'h000C, 32'h0, 4'b0001);
        chk_now("w1c_zero_noop", {31'b0, timer_int}, 32'h1);
        @(posedge clk); #1;
        wr(16'h000C, 32'h1, 4'b0001);
        chk_now("w1c_clear", {31'b0, timer_int}, 32'h0);
        @(posedge clk); #1;

        // Wrap: after COUNT write and CTRL edge COUNT=FFFF_FFFE, one idle edge -> FFFF_FFFF
        wr(16'h0000, 32'd0, 4'b0001);
        wr(16'h0004, 32'hFFFF_FFFE, 4'b1111);
        wr(16'h0000, 32'd1, 4'b0001);
        cyc();
        rd("count_ffff", 16'h0004, 32'hFFFF_FFFF);
        rd("count_wrap", 16'h0004, 32'h0000_0000);

        // COMPARE write on the matching cycle suppresses the set
        wr(16'h0000, 32'd0, 4'b0001);
        wr(16'h0008, 32'h100, 4'b1111);
        wr(16'h0004, 32'hFE, 4'b1111);
        wr(16'h000C, 32'h1, 4'b0001);
        wr(16'h0000, 32'd3, 4'b0001);
        cyc(); cyc();
        wr(16'h0008, 32'h5000, 4'b1111);
        chk_now("cmp_suppress_int", {31'b0, timer_int}, 32'h0);
        @(posedge clk); #1;
        rd("cmp_suppress_status", 16'h000C, 32'h0);
        wr(16'h0000, 32'd0, 4'b0001);
`else
        // No timer: registers read 0 and the interrupt never fires
        wr(16'h0008, 32'd0, 4'b1111);
        wr(16'h0004, 32'd0, 4'b1111);
        wr(16'h0000, 32'd3, 4'b0001);
        rd("count_off", 16'h0004, 32'h0);
        rd("ctrl_off", 16'h0000, 32'h0);
        repeat (5) cyc();
        chk_now("int_off", {31'b0, timer_int}, 32'h0);
        @(posedge clk); #1;
`endif

        // Reset in the middle of a read drops it and zeroes rdata
        rd("scratch_pre_rst", 16'h0018, 32'hA534_A578);
        sram_en = 1'b1; sram_wen = 4'b0; sram_addr = BASE | 32'h18; rst = 1'b1;
        cyc();
        sram_en = 1'b0; rst = 1'b0;
        chk_now("rst_mid_req", sram_rdata, 32'h0);
        @(posedge clk); #1;
        rd("scratch_post_rst", 16'h0018, 32'h0);

        cyc(); cyc();
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_confreg_responder.md
# sram_confreg_responder

Memory-mapped configuration-register responder on the data SRAM-style bus. Used by the SoC on the far side of the CPU's data SRAM port. Serves byte-enabled writes and one-cycle-latency reads for a small register window: control, timer, LED, switch and scratch registers. Raises a timer interrupt that is fed back into the CPU interrupt vector.

## Interface
Parameters:
- BASE_HI, 16'hBFAF, value that sram_addr[31:16] must equal for the window to be selected
- COUNT_INIT, 32'h0000_0000, COUNT reset value

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- sram_en  in  1  request valid this cycle
- sram_wen  in  4  byte write enables; 4'b0000 with sram_en means read
- sram_addr  in  32  byte address; [1:0] ignored
- sram_wdata  in  32  write data, byte lane i = bits [8i+7:8i]
- sram_rdata  out  32  read data, valid the cycle after the read request
- switch_in  in  8  asynchronous board switches
- led_out  out  16  LED register contents
- timer_int  out  1  level interrupt = STATUS.pending & CTRL.int_en

## Operation
- Hit: sram_en & (sram_addr[31:16]==BASE_HI). Offset = sram_addr[15:0].
- Register map:
  - 0x0000 CTRL: [0] timer_en, [1] int_en; other bits read 0.
  - 0x0004 COUNT: 32-bit. Increments by 1 each cycle while timer_en. Wraps from FFFF_FFFF to 0.
  - 0x0008 COMPARE: 32-bit, read/write.
  - 0x000C STATUS: [0] pending. Writing 1 to byte 0 bit 0 clears it (W1C). Writing 0 has no effect.
  - 0x0010 LED: bits [15:0] read/write; upper bits read 0.
  - 0x0014 SWITCH: read-only {24'b0, switch_sync}. switch_sync is a 2-flop synchronizer on switch_in.
  - 0x0018 SCRATCH: 32-bit, read/write.
- Writes:
  - Take effect at the edge where hit & sram_wen!=0.
  - Only lanes with wen[i]=1 are updated.
  - Writes to read-only or unmapped offsets are ignored, as are misses.
- Reads:
  - Occur on hit & sram_wen==0.
  - sram_rdata is registered and returns the register value as of the request cycle, before that edge's update.
  - Unmapped offsets return 0.
  - A miss read returns 0.
- sram_rdata holds its last value when there is no read request: cycles without sram_en, and write cycles.
- Pending set:
  - Condition: timer_en & (COUNT==COMPARE), evaluated on the current register values.
  - pending goes to 1 at that edge.
- Priority per edge:
  - A software write to COUNT overrides the increment.
  - A write to COMPARE clears pending and suppresses a match in that cycle.
  - Otherwise, a match set wins over a simultaneous STATUS W1C clear.

## Timing
- Reset, at a clock edge with rst=1:
  - CTRL=0, COUNT=COUNT_INIT, COMPARE=FFFF_FFFF, pending=0.
  - LED=0, SCRATCH=0, switch synchronizer=0.
  - Outputs: sram_rdata=0, led_out=0, timer_int=0.
- Reset during a request: the request is dropped, and the next cycle's sram_rdata=0.
- Read latency is 1 cycle. Back-to-back reads every cycle are supported.
- Write-then-read to the same offset in the next cycle returns the written value.
- COUNT read at request cycle N returns the value held during N. The next read, at N+1 with timer_en=1, returns that value +1.
- timer_int:
  - Asserts in the cycle after the matching edge.
  - Deasserts in the cycle after the clearing write or the CTRL.int_en clear.
- switch_in reaches SWITCH readback after 2 clock edges.

## Configuration
- CONFREG_TIMER_EN defined:
  - CTRL timer bits, COUNT, COMPARE and STATUS behave as above.
- CONFREG_TIMER_EN undefined:
  - No timer logic.
  - Offsets 0x0000–0x000C read 0; writes to them are ignored.
  - timer_int is tied to 0.
  - LED, SWITCH and SCRATCH are unchanged.

## Test plan
- Reset, then read LED, SCRATCH and COMPARE -> 0, 0, FFFF_FFFF one cycle after each request; timer_int=0.
- Write SCRATCH=A5A5_A5A5 (wen=1111), then write 1234_5678 with wen=0101 -> read returns A534_A578.
- Write COMPARE=10, COUNT=0, CTRL=3 -> timer_int rises 1 cycle after the edge where COUNT==10. Then write STATUS=1 -> timer_int low the next cycle.
- Set COUNT=FFFF_FFFE, CTRL=1, read COUNT on two consecutive cycles -> FFFF_FFFF then 0000_0000.
- Drive switch_in=8'h3C, wait 2 cycles, read 0x0014 -> 0000_003C. Write 0x0014 -> readback unchanged. Read with addr[31:16]!=BASE_HI -> 0.
- Write COMPARE in the same cycle COUNT equals the old COMPARE with pending=0 -> pending stays 0. Build without CONFREG_TIMER_EN -> COUNT reads 0 and timer_int is never asserted.
